// File: rtl/scm_bist_pkg.sv
// Shared types for the March C- register-file BIST controller: FSM states,
// march element table and background constants.
package scm_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  typedef struct packed {
    logic down;    // address order N-1..0
    logic has_rd;  // element starts with a read
    logic has_wr;  // element ends with a write
    logic rd_pol;  // read expects D1 (=~D0) when set
    logic wr_pol;  // write uses D1 when set
  } march_elem_t;

  localparam logic [2:0] LAST_ELEM   = 3'd5;
  localparam logic       BG_ZERO     = 1'b0;
  localparam logic       BG_ALT      = 1'b1;
  localparam logic [7:0] BG_ALT_BYTE = 8'h55;

  // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
  function automatic march_elem_t march_elem(input logic [2:0] e);
    march_elem_t m;
    case (e)
      3'd0:    m = 5'b0_0_1_0_0;
      3'd1:    m = 5'b0_1_1_0_1;
      3'd2:    m = 5'b0_1_1_1_0;
      3'd3:    m = 5'b1_1_1_0_1;
      3'd4:    m = 5'b1_1_1_1_0;
      3'd5:    m = 5'b0_1_0_0_0;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/scm_march_bist_ctrl.sv
// March C- BIST controller for a latch register file: two backgrounds, 20N ops back to back.
// done/busy-low 20N+2 cycles after start; start is ignored while busy (no other backpressure).
module scm_march_bist_ctrl
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  fail_bg,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  output logic [NUM_BYTE-1:0]   BE_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  function automatic logic [DATA_WIDTH-1:0] bg_pat(input logic b);
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < DATA_WIDTH; i++) p[i] = b & BG_ALT_BYTE[i[2:0]];
    return p;
  endfunction

  bist_state_e           state;
  logic [2:0]            elem;
  logic                  bg;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ph;
  logic                  pass_flag;

  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            rd_elem;
  logic                  rd_bg;

  march_elem_t           cur_info, nxt_info;
  logic [2:0]            nxt_elem;
  logic                  nxt_bg, nxt_ph, nxt_rd, wrap, cur_last, cur_rd, miscmp;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] cur_exp, nxt_wdat;

  // (elem, bg, addr, ph) names the operation currently on the test port
  always_comb begin
    cur_info = march_elem(elem);
    cur_rd   = cur_info.has_rd && !ph;
    cur_exp  = bg_pat(bg) ^ {DATA_WIDTH{cur_info.rd_pol}};
    cur_last = (bg == BG_ALT) && (elem == LAST_ELEM) && (addr == ADDR_MAX);
    nxt_elem = elem;
    nxt_bg   = bg;
    nxt_addr = addr;
    nxt_ph   = 1'b0;
    wrap     = 1'b0;
    if (cur_info.has_rd && cur_info.has_wr && !ph) begin
      nxt_ph = 1'b1;
    end else if (cur_info.down ? (addr == '0) : (addr == ADDR_MAX)) begin
      wrap = 1'b1;
      if (elem == LAST_ELEM) begin
        nxt_elem = 3'd0;
        nxt_bg   = BG_ALT;
      end else begin
        nxt_elem = elem + 3'd1;
      end
    end else begin
      nxt_addr = cur_info.down ? addr - 1'b1 : addr + 1'b1;
    end
    nxt_info = march_elem(nxt_elem);
    if (wrap) nxt_addr = nxt_info.down ? ADDR_MAX : '0;
    nxt_rd   = nxt_info.has_rd && !nxt_ph;
    nxt_wdat = bg_pat(nxt_bg) ^ {DATA_WIDTH{nxt_info.wr_pol}};
    miscmp   = rd_vld && (Q_T != rd_exp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      elem      <= 3'd0;
      bg        <= BG_ZERO;
      addr      <= '0;
      ph        <= 1'b0;
      pass_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      fail_bg   <= 1'b0;
      BIST      <= 1'b0;
      CSN_T     <= 1'b1;
      WEN_T     <= 1'b1;
      A_T       <= '0;
      D_T       <= '0;
      BE_T      <= '0;
      rd_vld    <= 1'b0;
      rd_exp    <= '0;
      rd_addr   <= '0;
      rd_elem   <= 3'd0;
      rd_bg     <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= 1'b0;
      if (miscmp && pass_flag) begin
        pass_flag <= 1'b0;
        fail_addr <= rd_addr;
        fail_elem <= rd_elem;
        fail_bg   <= rd_bg;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            BIST      <= 1'b1;
            elem      <= 3'd0;
            bg        <= BG_ZERO;
            addr      <= '0;
            ph        <= 1'b0;
            pass_flag <= 1'b1;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            fail_bg   <= 1'b0;
            CSN_T     <= 1'b0;
            WEN_T     <= 1'b0;
            A_T       <= '0;
            D_T       <= bg_pat(BG_ZERO);
            BE_T      <= '1;
          end
        end
        ST_RUN: begin
          rd_vld  <= cur_rd;
          rd_exp  <= cur_exp;
          rd_addr <= addr;
          rd_elem <= elem;
          rd_bg   <= bg;
          if (cur_last) begin
            state <= ST_DRAIN;
            CSN_T <= 1'b1;
            WEN_T <= 1'b1;
            A_T   <= '0;
            D_T   <= '0;
            BE_T  <= '0;
          end else begin
            elem  <= nxt_elem;
            bg    <= nxt_bg;
            addr  <= nxt_addr;
            ph    <= nxt_ph;
            CSN_T <= 1'b0;
            WEN_T <= nxt_rd;
            A_T   <= nxt_addr;
            D_T   <= nxt_rd ? '0 : nxt_wdat;
            BE_T  <= '1;
          end
        end
        ST_DRAIN: begin
          // last E5 read is compared this cycle, so fold it into the reported result
          state <= ST_DONE;
          busy  <= 1'b0;
          BIST  <= 1'b0;
          done  <= 1'b1;
          pass  <= pass_flag && !miscmp;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scm_march_bist_ctrl.sv
// Randomized bench for scm_march_bist_ctrl: faulty register-file model plus an op-list reference.
module tb_scm_march_bist_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int N  = 32;
  localparam int NOPS = 20 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, fail_bg, BIST, CSN_T, WEN_T;
  logic [AW-1:0] fail_addr, A_T;
  logic [2:0]    fail_elem;
  logic [DW-1:0] D_T, Q_T;
  logic [NB-1:0] BE_T;

  scm_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bg(fail_bg),
    .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .BE_T(BE_T), .Q_T(Q_T)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // register file with an optional single stuck-at bit
  bit          f_en = 0;
  int          f_addr = 0;
  int          f_bit = 0;
  bit          f_val = 0;
  logic [DW-1:0] mem [N];

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!CSN_T) begin
      if (!WEN_T) mem[A_T] <= D_T;
      else        Q_T <= faulty(int'(A_T), mem[A_T]);
    end
  end

  // reference op list derived from the March C- definition
  typedef struct {
    bit            wr;
    int            addr;
    logic [DW-1:0] data;
    int            elem;
    int            bg;
  } op_t;
  op_t exp_ops[$];
  int  obs_a [NOPS];
  bit  obs_wen [NOPS];

  task automatic build_ops();
    int nops[6]     = '{1, 2, 2, 2, 2, 1};
    bit first_rd[6] = '{0, 1, 1, 1, 1, 1};
    bit pol1[6]     = '{0, 0, 1, 0, 1, 0};
    bit down[6]     = '{0, 0, 0, 1, 1, 0};
    logic [DW-1:0] d0, dv;
    op_t o;
    exp_ops.delete();
    for (int b = 0; b < 2; b++) begin
      d0 = (b == 1) ? 32'h5555_5555 : 32'h0;
      for (int e = 0; e < 6; e++) begin
        for (int k = 0; k < N; k++) begin
          o.addr = down[e] ? N - 1 - k : k;
          o.elem = e;
          o.bg   = b;
          dv     = pol1[e] ? ~d0 : d0;
          o.wr   = !first_rd[e];
          o.data = dv;
          exp_ops.push_back(o);
          if (nops[e] == 2) begin
            o.wr   = 1;
            o.data = ~dv;
            exp_ops.push_back(o);
          end
        end
      end
    end
  endtask

  task automatic predict(output bit e_pass, output int e_addr, output int e_elem, output int e_bg);
    logic [DW-1:0] m [N];
    e_pass = 1; e_addr = 0; e_elem = 0; e_bg = 0;
    foreach (exp_ops[i]) begin
      if (exp_ops[i].wr) m[exp_ops[i].addr] = exp_ops[i].data;
      else if (e_pass && faulty(exp_ops[i].addr, m[exp_ops[i].addr]) !== exp_ops[i].data) begin
        e_pass = 0;
        e_addr = exp_ops[i].addr;
        e_elem = exp_ops[i].elem;
        e_bg   = exp_ops[i].bg;
      end
    end
  endtask

  // one full run from IDLE; pulse_at >= 0 pulses start during that op index
  task automatic run_march(input string name, input int pulse_at);
    bit e_pass;
    int e_addr, e_elem, e_bg;
    predict(e_pass, e_addr, e_elem, e_bg);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NOPS; i++) begin
      start = (i == pulse_at);
      obs_a[i]   = int'(A_T);
      obs_wen[i] = WEN_T;
      total++;
      if (busy !== 1'b1 || BIST !== 1'b1 || CSN_T !== 1'b0 || BE_T !== 4'hF ||
          WEN_T !== !exp_ops[i].wr || int'(A_T) != exp_ops[i].addr ||
          (exp_ops[i].wr && D_T !== exp_ops[i].data)) begin
        bad++;
        $display("FAIL %s op%0d: got busy=%b BIST=%b CSN=%b WEN=%b A=%0d D=%h BE=%h, want WEN=%b A=%0d D=%h",
                 name, i, busy, BIST, CSN_T, WEN_T, A_T, D_T, BE_T,
                 !exp_ops[i].wr, exp_ops[i].addr, exp_ops[i].data);
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || CSN_T !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s drain: got busy=%b CSN=%b done=%b, want 1 1 0", name, busy, CSN_T, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || BIST !== 1'b0 || pass !== e_pass) begin
      bad++;
      $display("FAIL %s done: got done=%b busy=%b BIST=%b pass=%b, want 1 0 0 %b",
               name, done, busy, BIST, pass, e_pass);
    end
    if (!e_pass) begin
      total++;
      if (int'(fail_addr) != e_addr || int'(fail_elem) != e_elem || int'(fail_bg) != e_bg) begin
        bad++;
        $display("FAIL %s capture: got addr=%0d elem=%0d bg=%0d, want %0d %0d %0d",
                 name, fail_addr, fail_elem, fail_bg, e_addr, e_elem, e_bg);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after: got done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 0 || done !== 0 || pass !== 0 || BIST !== 0 || CSN_T !== 1 || WEN_T !== 1 ||
        A_T !== '0 || D_T !== '0 || BE_T !== '0 || fail_addr !== '0 || fail_elem !== '0 || fail_bg !== 0) begin
      bad++;
      $display("FAIL reset: got busy=%b done=%b pass=%b BIST=%b CSN=%b WEN=%b A=%h D=%h BE=%h fa=%h fe=%h fb=%b",
               busy, done, pass, BIST, CSN_T, WEN_T, A_T, D_T, BE_T, fail_addr, fail_elem, fail_bg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    f_en = 0;
    run_march("fault_free", -1);
    total++;
    if (obs_a[0] != 0 || obs_a[1] != 1 || obs_a[2] != 2 || obs_wen[0] || obs_wen[1] || obs_wen[2]) begin
      bad++;
      $display("FAIL first_ops: got A=%0d,%0d,%0d WEN=%b%b%b, want A=0,1,2 WEN=000",
               obs_a[0], obs_a[1], obs_a[2], obs_wen[0], obs_wen[1], obs_wen[2]);
    end
    total++;
    if (obs_a[5*N] != 31 || obs_wen[5*N] !== 1'b1) begin
      bad++;
      $display("FAIL e3_first: got A=%0d WEN=%b, want A=31 WEN=1", obs_a[5*N], obs_wen[5*N]);
    end
  endtask

  task automatic test_stuck_faults();
    f_en = 1; f_addr = 7; f_bit = 3; f_val = 1;
    run_march("sa1_a7_b3", -1);
    total++;
    if (pass !== 0 || fail_addr !== 5'd7 || fail_elem !== 3'd1 || fail_bg !== 0) begin
      bad++;
      $display("FAIL sa1_fixed: got pass=%b addr=%0d elem=%0d bg=%b, want 0 7 1 0",
               pass, fail_addr, fail_elem, fail_bg);
    end
    f_addr = 31; f_bit = 0; f_val = 0;
    run_march("sa0_a31_b0", -1);
    total++;
    if (pass !== 0 || fail_addr !== 5'd31 || fail_elem !== 3'd2 || fail_bg !== 0) begin
      bad++;
      $display("FAIL sa0_fixed: got pass=%b addr=%0d elem=%0d bg=%b, want 0 31 2 0",
               pass, fail_addr, fail_elem, fail_bg);
    end
  endtask

  task automatic test_random_faults();
    for (int t = 0; t < 4; t++) begin
      f_en   = ($urandom_range(0, 3) != 0);
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, DW - 1);
      f_val  = $urandom_range(0, 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_march($sformatf("rand%0d", t), -1);
    end
    f_en = 0;
  endtask

  task automatic test_reset_mid();
    int dc;
    f_en = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (BIST !== 0 || CSN_T !== 1 || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_mid: got BIST=%b CSN=%b busy=%b done=%b, want 0 1 0 0", BIST, CSN_T, busy, done);
    end
    rst = 1'b0;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    total++;
    if (done_cnt != dc || busy !== 0) begin
      bad++;
      $display("FAIL reset_nodone: got done pulses=%0d busy=%b, want 0 0", done_cnt - dc, busy);
    end
    run_march("after_reset", -1);
  endtask

  task automatic test_start_while_busy();
    int dc;
    dc = done_cnt;
    run_march("busy_start", 100 + $urandom_range(0, 400));
    repeat (NOPS + 10) @(negedge clk);
    total++;
    if (done_cnt - dc != 1 || busy !== 0) begin
      bad++;
      $display("FAIL busy_start_single: got done pulses=%0d busy=%b, want 1 0", done_cnt - dc, busy);
    end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    int  dc;
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < NOPS + 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (done !== 1'b1 || cyc != NOPS + 2) begin
      bad++;
      $display("FAIL b2b_first_done: got done=%b after %0d cycles, want 1 after %0d", done, cyc, NOPS + 2);
    end
    @(negedge clk);
    total++;
    if (busy !== 0 || done !== 0 || CSN_T !== 1) begin
      bad++;
      $display("FAIL b2b_idle: got busy=%b done=%b CSN=%b, want 0 0 1", busy, done, CSN_T);
    end
    @(negedge clk);
    total++;
    if (busy !== 1 || CSN_T !== 0 || WEN_T !== 0 || A_T !== '0) begin
      bad++;
      $display("FAIL b2b_restart: got busy=%b CSN=%b WEN=%b A=%0d, want 1 0 0 0", busy, CSN_T, WEN_T, A_T);
    end
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < NOPS + 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    total++;
    if (done_cnt - dc != 2 || pass !== 1'b1) begin
      bad++;
      $display("FAIL b2b_count: got done pulses=%0d pass=%b, want 2 1", done_cnt - dc, pass);
    end
  endtask

  initial begin
    build_ops();
    test_reset();
    test_fault_free();
    test_stuck_faults();
    test_random_faults();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scm_march_bist_ctrl.md
SCM_MARCH_BIST_CTRL -- requirements
Module: scm_march_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register-file address width; word count N = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning test-port data width.
REQ-003 SHALL have parameter NUM_BYTE, default DATA_WIDTH/8, meaning byte-enable width.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
REQ-005 SHALL have these control and status ports:
- start  input  1  begin test; sampled only in IDLE.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  result of last completed test; held until next start.
- fail_addr  output  ADDR_WIDTH  address of first miscompare.
- fail_elem  output  3  march element (0-5) of first miscompare.
- fail_bg  output  1  background pass (0/1) of first miscompare.
REQ-006 SHALL have these memory test-port ports:
- BIST  output  1  test-mode select to the register file.
- CSN_T  output  1  chip select, active low.
- WEN_T  output  1  write enable, active low.
- A_T  output  ADDR_WIDTH  address.
- D_T  output  DATA_WIDTH  write data.
- BE_T  output  NUM_BYTE  byte enables.
- Q_T  input  DATA_WIDTH  read data, valid the cycle after a read.

Function
REQ-007 SHALL run March C- twice: background 0 with D0 = all-zero, then background 1 with D0 = 0x55..55; in each background D1 = ~D0.
REQ-008 SHALL execute these elements in order:
- E0 up(w0)
- E1 up(r0,w1)
- E2 up(r1,w0)
- E3 down(r0,w1)
- E4 down(r1,w0)
- E5 up(r0)
"up" is address 0..N-1 and "down" is N-1..0.
REQ-009 SHALL issue one operation per cycle with no idle cycles, including between elements and between backgrounds; two-operation elements issue the read then the write at the same address. Total is 20N operation cycles.
REQ-010 Operation encoding:
- Read: CSN_T=0, WEN_T=1.
- Write: CSN_T=0, WEN_T=0, D_T = pattern.
- BE_T = all-ones whenever CSN_T=0, otherwise 0.
REQ-011 SHALL hold BIST=1 whenever busy=1, and BIST=0 otherwise.
REQ-012 Compare pipeline: expected data, address, element and background of each read SHALL be registered; Q_T SHALL be compared in the following cycle, with full-word equality.
REQ-013 On the first miscompare, SHALL capture fail_addr, fail_elem and fail_bg and clear the pass flag. Later miscompares SHALL NOT overwrite the capture, and the test SHALL continue to completion.
REQ-014 FSM states and transitions:
- IDLE -> RUN on start=1.
- RUN -> DRAIN after the last E5 read of background 1.
- DRAIN (1 cycle, final compare) -> DONE.
- DONE (done=1, 1 cycle) -> IDLE.
REQ-015 Timing: with start sampled high at edge k, the first operation (write, A_T=0) SHALL be driven in cycle k+1 and busy=1 from cycle k+1. done=1 and busy=0 SHALL occur in cycle k+20N+2.
REQ-016 start while busy SHALL be ignored. If start is held high, a new test SHALL begin from IDLE the cycle after DONE.
REQ-017 On start, SHALL set the internal pass flag to 1 and clear the fail captures to 0. The pass output SHALL update only in the DONE cycle.
REQ-018 Address counter wrap: at N-1 (up) or 0 (down), the counter SHALL advance to the first address of the next element in the same cycle.

Reset
REQ-019 rst=1 SHALL force, at the next edge:
- state IDLE; busy, done and pass = 0.
- BIST=0, CSN_T=1, WEN_T=1.
- A_T, D_T, BE_T, fail_addr, fail_elem, fail_bg = 0.
REQ-020 Reset mid-test SHALL abort the test with no done pulse; the pipelined compare SHALL be discarded.

Structure
REQ-021 Shared package scm_bist_pkg SHALL hold:
- FSM state enum.
- March element table (direction, op count, read/write data polarity).
- Background constants.
REQ-022 SHALL be a single module with no sub-module; address generation, sequencing and the comparator are in-line.

Verification
REQ-023 Fault-free register-file model, N=32, start at edge k -> 640 operation cycles, done=1 at cycle k+642, pass=1, BIST=0 after.
REQ-024 First cycles after start -> A_T=0,1,2 with WEN_T=0 and D_T=0. The first E3 operation has A_T=31 and WEN_T=1.
REQ-025 Model with addr 7 bit 3 stuck-at-1 -> pass=0, fail_addr=7, fail_elem=1, fail_bg=0; test still runs the full 640 cycles.
REQ-026 Model with addr 31 bit 0 stuck-at-0 -> fail_addr=31, fail_elem=2, fail_bg=0.
REQ-027 Assert rst at cycle 300 of a run -> next cycle BIST=0, CSN_T=1, busy=0, no done pulse; a subsequent start runs a full test.
REQ-028 start pulsed during busy -> ignored, single done. start held high -> back-to-back tests separated by exactly one IDLE cycle.
